// File: rtl/eff_chain_pkg.sv
// eff_chain_pkg: shared types, default widths and slot slicing helper for the
// effect chain. The crossfade build is selected by EFF_CHAIN_FADE_EN.
package eff_chain_pkg;

    localparam int unsigned NUM_STAGES_DEF = 5;
    localparam int unsigned NUM_CH_DEF     = 2;
    localparam int unsigned DATA_WIDTH_DEF = 24;
    localparam int unsigned FADE_SHIFT_DEF = 8;
    localparam int unsigned DRY_DEPTH_DEF  = 16;

    typedef enum logic [1:0] {OFF, FADE_IN, ON, FADE_OUT} fade_state_t;

    // LSB offset of slot k inside a flat per-slot bus of w-bit words
    function automatic int unsigned slot_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/eff_chain_if.sv
// eff_chain_if: send/return streams between the chain and the external
// effect modules. Slot k occupies [k*W +: W], W = NUM_CH*DATA_WIDTH.
//   master (chain side) : drives snd_data/snd_vld, receives ret_data/ret_vld
//   slave  (effect side): the mirror image
interface eff_chain_if
    import eff_chain_pkg::*;
#(
    parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
    parameter int unsigned NUM_CH     = NUM_CH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
    localparam int unsigned W = NUM_CH * DATA_WIDTH;

    logic [NUM_STAGES*W-1:0] snd_data;
    logic [NUM_STAGES-1:0]   snd_vld;
    logic [NUM_STAGES*W-1:0] ret_data;
    logic [NUM_STAGES-1:0]   ret_vld;

    modport master (output snd_data, output snd_vld, input ret_data, input ret_vld);
    modport slave  (input snd_data, input snd_vld, output ret_data, output ret_vld);

endinterface

// File: rtl/eff_chain_stage.sv
// eff_chain_stage: one effect slot. Registers the source sample onto the send
// port, keeps a latency-matched dry copy in a FIFO, and mixes dry/wet on each
// return with a gain driven by the fade FSM.
//   tgt               : registered slot enable request
//   src_data/src_vld  : incoming sample
//   snd_data/snd_vld  : sample to the effect (always fed)
//   ret_data/ret_vld  : effect output
//   mix_data/mix_vld  : mixed output, one cycle after ret_vld
//   err               : sticky dry FIFO overflow/underflow
// With EFF_CHAIN_FADE_EN defined the gain ramps by one step per mix event;
// otherwise it jumps between 0 and max and the mixer is a plain mux.
module eff_chain_stage
    import eff_chain_pkg::*;
#(
    parameter int unsigned NUM_CH     = NUM_CH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FADE_SHIFT = FADE_SHIFT_DEF,
    parameter int unsigned DRY_DEPTH  = DRY_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tgt,
    input  logic [NUM_CH*DATA_WIDTH-1:0] src_data,
    input  logic                         src_vld,
    output logic [NUM_CH*DATA_WIDTH-1:0] snd_data,
    output logic                         snd_vld,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ret_data,
    input  logic                         ret_vld,
    output logic [NUM_CH*DATA_WIDTH-1:0] mix_data,
    output logic                         mix_vld,
    output logic                         err
);
    localparam int unsigned W  = NUM_CH * DATA_WIDTH;
    localparam int unsigned AW = $clog2(DRY_DEPTH);
    localparam int unsigned GW = FADE_SHIFT + 1;
    localparam logic [GW-1:0] G_MAX = GW'(1) << FADE_SHIFT;

    logic [W-1:0]  mem [DRY_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop;
    logic [W-1:0]  dry, mixed;
    fade_state_t   state, state_n;
    logic [GW-1:0] g, g_n;

    // Pointer MSB distinguishes full from empty
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ret_vld & ~empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push
    assign push  = src_vld & (~full | pop);
    assign dry   = mem[rd_ptr[AW-1:0]];

    // Dry storage (no reset needed; only read when non-empty)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= src_data;
    end

    // Datapath registers, FIFO pointers, sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            snd_data <= '0;
            snd_vld  <= 1'b0;
            mix_data <= '0;
            mix_vld  <= 1'b0;
            err      <= 1'b0;
        end else begin
            snd_vld <= src_vld;
            if (src_vld) snd_data <= src_data;
            mix_vld <= pop;
            if (pop) mix_data <= mixed;
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if ((src_vld & full & ~pop) | (ret_vld & empty)) err <= 1'b1;
        end
    end

    // Fade state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
            g     <= '0;
        end else begin
            state <= state_n;
            g     <= g_n;
        end
    end

`ifdef EFF_CHAIN_FADE_EN
    localparam int unsigned PW = DATA_WIDTH + FADE_SHIFT + 2;

    logic [GW-1:0] g_up, g_dn;
    assign g_up = g + GW'(1);
    assign g_dn = g - GW'(1);

    // Gain steps toward the target once per mix event; reversal needs no jump
    always_comb begin
        state_n = state;
        g_n     = g;
        if (pop) begin
            case (state)
                OFF: if (tgt) begin
                    g_n     = g_up;
                    state_n = (g_up == G_MAX) ? ON : FADE_IN;
                end
                ON: if (!tgt) begin
                    g_n     = g_dn;
                    state_n = (g_dn == '0) ? OFF : FADE_OUT;
                end
                FADE_IN, FADE_OUT: begin
                    if (tgt) begin
                        g_n     = g_up;
                        state_n = (g_up == G_MAX) ? ON : FADE_IN;
                    end else begin
                        g_n     = g_dn;
                        state_n = (g_dn == '0) ? OFF : FADE_OUT;
                    end
                end
                default: begin
                    g_n     = '0;
                    state_n = OFF;
                end
            endcase
        end
    end

    // Per-channel crossfade: dry + floor((wet - dry) * g / 2^FADE_SHIFT)
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [DATA_WIDTH-1:0] dry_c, wet_c;
        logic signed [DATA_WIDTH:0]   diff;
        logic signed [PW-1:0]         gain_x, prod;
        assign dry_c  = dry[c*DATA_WIDTH +: DATA_WIDTH];
        assign wet_c  = ret_data[c*DATA_WIDTH +: DATA_WIDTH];
        assign diff   = (DATA_WIDTH+1)'(wet_c) - (DATA_WIDTH+1)'(dry_c);
        assign gain_x = PW'($signed({1'b0, g}));
        assign prod   = PW'(diff) * gain_x;
        assign mixed[c*DATA_WIDTH +: DATA_WIDTH] = dry_c + DATA_WIDTH'(prod >>> FADE_SHIFT);
    end
`else
    // Hard switch between dry and wet at the next mix event
    always_comb begin
        state_n = state;
        g_n     = g;
        if (pop) begin
            case (state)
                OFF: if (tgt) begin
                    g_n     = G_MAX;
                    state_n = ON;
                end
                ON: if (!tgt) begin
                    g_n     = '0;
                    state_n = OFF;
                end
                default: begin
                    g_n     = '0;
                    state_n = OFF;
                end
            endcase
        end
    end

    assign mixed = (g == G_MAX) ? ret_data : dry;
`endif

endmodule

// File: rtl/eff_chain.sv
// eff_chain: NUM_STAGES effect slots in series with click-free enable
// switching. Slot 0 takes data_i, each later slot takes the previous slot's
// mix output, and the last slot drives data_o.
//   clk, rst_n     : clock, async active-low reset
//   en, sel        : global and per-slot enable requests
//   data_i/vld_i   : input sample
//   data_o/vld_o   : output sample
//   err            : sticky per-slot dry FIFO error
//   fx             : effect send/return bus (eff_chain_if.master)
// Optional build macro: EFF_CHAIN_FADE_EN (crossfade instead of hard switch).
module eff_chain
    import eff_chain_pkg::*;
#(
    parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
    parameter int unsigned NUM_CH     = NUM_CH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FADE_SHIFT = FADE_SHIFT_DEF,
    parameter int unsigned DRY_DEPTH  = DRY_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [NUM_STAGES-1:0]        sel,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
    input  logic                         vld_i,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_o,
    output logic                         vld_o,
    output logic [NUM_STAGES-1:0]        err,
    eff_chain_if.master                  fx
);
    localparam int unsigned W = NUM_CH * DATA_WIDTH;

    logic [NUM_STAGES-1:0]        tgt;
    logic [NUM_STAGES:0][W-1:0]   chain_data;
    logic [NUM_STAGES:0]          chain_vld;
    logic [NUM_STAGES*W-1:0]      snd_flat;
    logic [NUM_STAGES-1:0]        snd_vld;

    // Per-slot target, sampled by each slot only at its mix events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tgt <= '0;
        else        tgt <= {NUM_STAGES{en}} & sel;
    end

    assign chain_data[0] = data_i;
    assign chain_vld[0]  = vld_i;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        eff_chain_stage #(
            .NUM_CH     (NUM_CH),
            .DATA_WIDTH (DATA_WIDTH),
            .FADE_SHIFT (FADE_SHIFT),
            .DRY_DEPTH  (DRY_DEPTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .tgt      (tgt[k]),
            .src_data (chain_data[k]),
            .src_vld  (chain_vld[k]),
            .snd_data (snd_flat[slot_lo(k, W) +: W]),
            .snd_vld  (snd_vld[k]),
            .ret_data (fx.ret_data[slot_lo(k, W) +: W]),
            .ret_vld  (fx.ret_vld[k]),
            .mix_data (chain_data[k+1]),
            .mix_vld  (chain_vld[k+1]),
            .err      (err[k])
        );
    end

    assign fx.snd_data = snd_flat;
    assign fx.snd_vld  = snd_vld;
    assign data_o      = chain_data[NUM_STAGES];
    assign vld_o       = chain_vld[NUM_STAGES];

endmodule

// File: tb/tb_eff_chain.sv
// tb_eff_chain: scoreboard bench for eff_chain with loopback effects
// (identity or negation, configurable latency) and a sample-level model.
module tb_eff_chain;
    localparam int NS = 2;
    localparam int NC = 2;
    localparam int DW = 24;
    localparam int FS = 2;
    localparam int DD = 16;
    localparam int W  = NC * DW;
    localparam int GMAX = 1 << FS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [NS-1:0] sel = '0;
    logic [W-1:0]  data_i = '0;
    logic          vld_i = 1'b0;
    logic [W-1:0]  data_o;
    logic          vld_o;
    logic [NS-1:0] err;

    eff_chain_if #(.NUM_STAGES(NS), .NUM_CH(NC), .DATA_WIDTH(DW)) fx ();

    eff_chain #(
        .NUM_STAGES(NS), .NUM_CH(NC), .DATA_WIDTH(DW), .FADE_SHIFT(FS), .DRY_DEPTH(DD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
        .data_i(data_i), .vld_i(vld_i), .data_o(data_o), .vld_o(vld_o),
        .err(err), .fx(fx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [W-1:0] d; int due; } item_t;
    item_t exp_q[$];
    item_t pend[NS][$];

    int lat[NS];
    bit neg[NS];
    int g_ref[NS];
    bit spur = 1'b0;
    int n_tests = 0;
    int n_fail  = 0;

`ifdef EFF_CHAIN_FADE_EN
    int b_exp[6] = '{400, 200, 0, -200, -400, -400};
    int c_exp[5] = '{400, 200, 0, 200, 400};
`else
    int b_exp[6] = '{400, -400, -400, -400, -400, -400};
    int c_exp[5] = '{400, -400, -400, 400, 400};
`endif

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [W-1:0] mk(input int a, input int b);
        logic [W-1:0] r;
        r[DW-1:0] = DW'(a);
        r[W-1:DW] = DW'(b);
        return r;
    endfunction

    function automatic int rnd();
        return int'($urandom_range(8388607, 0)) - 4194304;
    endfunction

    function automatic longint chv(input logic [W-1:0] x, input int c);
        logic [DW-1:0] t;
        t = x[c*DW +: DW];
        return longint'($signed(t));
    endfunction

    function automatic logic [W-1:0] effect(input int k, input logic [W-1:0] x);
        logic [W-1:0]  r;
        logic [DW-1:0] t;
        r = x;
        if (neg[k]) begin
            for (int c = 0; c < NC; c++) begin
                t = x[c*DW +: DW];
                r[c*DW +: DW] = DW'(0) - t;
            end
        end
        return r;
    endfunction

    // dry + floor((wet - dry) * g / 2^FS), computed with plain integer division
    function automatic longint mix_ref(input longint dry, input longint wet, input int g);
        longint p, q, d;
        d = longint'(GMAX);
        p = (wet - dry) * longint'(g);
        q = p / d;
        if ((p % d) != 0 && p < 0) q = q - 1;
        return dry + q;
    endfunction

    function automatic int tot_lat();
        int s = 0;
        for (int k = 0; k < NS; k++) s += 2 + lat[k];
        return s;
    endfunction

    // Whole-chain model for one sample; advances each slot's gain afterwards
    task automatic model(input logic [W-1:0] x, output logic [W-1:0] y);
        logic [W-1:0] cur, wet, nxt;
        longint o;
        bit t;
        cur = x;
        for (int k = 0; k < NS; k++) begin
            wet = effect(k, cur);
            for (int c = 0; c < NC; c++) begin
                o = mix_ref(chv(cur, c), chv(wet, c), g_ref[k]);
                nxt[c*DW +: DW] = o[DW-1:0];
            end
            t = en & sel[k];
`ifdef EFF_CHAIN_FADE_EN
            if (t) g_ref[k] = (g_ref[k] < GMAX) ? g_ref[k] + 1 : GMAX;
            else   g_ref[k] = (g_ref[k] > 0) ? g_ref[k] - 1 : 0;
`else
            g_ref[k] = t ? GMAX : 0;
`endif
            cur = nxt;
        end
        y = cur;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: push model result, 1: push e, 2: push nothing
    task automatic send(input logic [W-1:0] x, input int mode, input logic [W-1:0] e);
        logic [W-1:0] y;
        item_t it;
        model(x, y);
        data_i = x;
        vld_i  = 1'b1;
        it.d   = (mode == 1) ? e : y;
        it.due = cyc + tot_lat();
        if (mode != 2) exp_q.push_back(it);
        tick();
        vld_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d outputs never arrived", exp_q.size());
            exp_q.delete();
        end
        repeat (2) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        exp_q.delete();
        for (int k = 0; k < NS; k++) g_ref[k] = 0;
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    // Loopback effects: one return per send after lat[k] cycles
    initial begin
        logic [NS-1:0]   rv;
        logic [NS*W-1:0] rdat;
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                for (int k = 0; k < NS; k++) pend[k].delete();
                fx.ret_vld = '0;
            end else begin
                for (int k = 0; k < NS; k++) begin
                    if (fx.snd_vld[k]) begin
                        it.d   = effect(k, fx.snd_data[k*W +: W]);
                        it.due = cyc + lat[k];
                        pend[k].push_back(it);
                    end
                end
                rv   = '0;
                rdat = '0;
                for (int k = 0; k < NS; k++) begin
                    if (pend[k].size() > 0 && pend[k][0].due == cyc) begin
                        rv[k] = 1'b1;
                        rdat[k*W +: W] = pend[k][0].d;
                        void'(pend[k].pop_front());
                    end
                end
                if (spur) begin
                    rv[1] = 1'b1;
                    rdat[W +: W] = W'($urandom);
                    spur = 1'b0;
                end
                fx.ret_vld  = rv;
                fx.ret_data = rdat;
            end
        end
    end

    // Monitor: every output must match the head of the scoreboard
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            if (rst_n && vld_o) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_vld_o: data_o %h with nothing expected (cyc %0d)", data_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 64'(data_o), 64'(e.d));
                    chk("out_cycle", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < NS; k++) begin
            lat[k] = 3;
            neg[k] = 1'b0;
            g_ref[k] = 0;
        end
        fx.ret_vld  = '0;
        fx.ret_data = '0;
        repeat (3) tick();
        chk("rst_data_o", 64'(data_o), 64'd0);
        chk("rst_vld_o", 64'(vld_o), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_snd_vld", 64'(fx.snd_vld), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Bypass: bit-exact dry, latency 10
        for (int i = 0; i < 10; i++) send(mk(1000, -1000), 1, mk(1000, -1000));
        drain();
        chk("bypass_err", 64'(err), 64'd0);

        // Fade in with a negating slot 0
        do_reset();
        neg[0] = 1'b1;
        en = 1'b1;
        sel = 2'b01;
        repeat (2) tick();
        for (int i = 0; i < 6; i++) send(mk(400, -400), 1, mk(b_exp[i], -b_exp[i]));
        drain();

        // Ramp reversal after two samples
        en = 1'b0;
        sel = 2'b00;
        do_reset();
        en = 1'b1;
        sel = 2'b01;
        repeat (2) tick();
        for (int i = 0; i < 2; i++) send(mk(400, -400), 1, mk(c_exp[i], -c_exp[i]));
        drain();
        sel = 2'b00;
        repeat (2) tick();
        for (int i = 2; i < 5; i++) send(mk(400, -400), 1, mk(c_exp[i], -c_exp[i]));
        drain();

        // Full FIFO with push and pop on the same edge
        en = 1'b0;
        sel = 2'b00;
        neg[0] = 1'b0;
        lat[0] = 15;
        do_reset();
        for (int i = 0; i < 40; i++) send(mk(rnd(), rnd()), 0, '0);
        drain();
        chk("full_pushpop_err", 64'(err), 64'd0);

        // Overflow on the 17th outstanding send
        lat[0] = 20;
        do_reset();
        for (int i = 0; i < 16; i++) send(mk(rnd(), rnd()), 0, '0);
        chk("sixteen_outstanding_err", 64'(err), 64'd0);
        send(mk(rnd(), rnd()), 2, '0);
        chk("overflow_err", 64'(err), 64'b01);
        drain();
        repeat (30) tick();

        // Randomised rounds
        lat[0] = 3;
        do_reset();
        for (int r = 0; r < 8; r++) begin
            en = 1'($urandom);
            sel = NS'($urandom);
            for (int k = 0; k < NS; k++) begin
                neg[k] = 1'($urandom);
                lat[k] = 1 + int'($urandom_range(11, 0));
            end
            repeat (2) tick();
            for (int i = 0; i < 20; i++) begin
                if ($urandom_range(1, 0) == 1) send(mk(rnd(), rnd()), 0, '0);
                else tick();
            end
            drain();
        end

        // Spurious return on slot 1
        spur = 1'b1;
        repeat (6) tick();
        chk("underflow_err", 64'(err), 64'b10);

        // Asynchronous reset while an output is valid
        send(mk(rnd(), rnd()), 0, '0);
        n = 0;
        while (!vld_o && n < 200) begin
            tick();
            n++;
        end
        chk("async_vld_seen", 64'(vld_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld_o", 64'(vld_o), 64'd0);
        chk("async_rst_err", 64'(err), 64'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eff_chain.md
Name: eff_chain

Overview:
- Parametrised successor to the fixed five-effect pipe. NUM_STAGES effect slots, NUM_CH packed channels, generic DATA_WIDTH.
- Each slot exposes a send/return stream to an external effect module. The block keeps a latency-matched dry copy per slot and crossfades dry/wet when the slot's enable changes, so switching is click-free.
- Sits between the codec sample interface and the output formatter.

Parameters:
- NUM_STAGES, 5: number of effect slots.
- NUM_CH, 2: channels packed per sample word; channel 0 in the LSBs.
- DATA_WIDTH, 24: signed bits per channel.
- FADE_SHIFT, 8: crossfade length is 2^FADE_SHIFT output samples.
- DRY_DEPTH, 16: dry FIFO entries per slot; a power of 2 no smaller than 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global effect enable.
- sel  in  NUM_STAGES  per-slot enable request.
- data_i  in  NUM_CH*DATA_WIDTH  input sample.
- vld_i  in  1  input sample valid.
- data_o  out  NUM_CH*DATA_WIDTH  output sample.
- vld_o  out  1  output valid.
- snd_data  out  NUM_STAGES*NUM_CH*DATA_WIDTH  samples sent to effects; slot k at [k*W +: W], where W = NUM_CH*DATA_WIDTH.
- snd_vld  out  NUM_STAGES  send valid.
- ret_data  in  NUM_STAGES*NUM_CH*DATA_WIDTH  effect outputs (wet).
- ret_vld  in  NUM_STAGES  return valid.
- err  out  NUM_STAGES  sticky per-slot dry FIFO overflow/underflow flag.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFOs empty, gain 0, FSM OFF, target registers 0.
- tgt[k] is registered each cycle as en & sel[k]. The FSM acts on tgt[k] only at mix events, i.e. at sample boundaries.
- Slot source:
  - Slot 0 source is data_i/vld_i.
  - Slot k source is the mix output of slot k-1.
  - data_o/vld_o is the mix output of slot NUM_STAGES-1.
- On source valid, in the same edge:
  - Push the source sample into the dry FIFO.
  - Register the sample onto snd_data; assert snd_vld for 1 cycle.
- Effects are always fed, regardless of enable, so their internal state stays continuous.
- Effect contract:
  - Exactly one return per send, in order, any latency.
  - Outstanding sends must not exceed DRY_DEPTH.
- On ret_vld[k]:
  - Pop the dry FIFO and compute per channel: out = dry + ((wet - dry) * g) >>> FADE_SHIFT.
  - wet - dry is computed at DATA_WIDTH+1 bits signed; the product is DATA_WIDTH+FADE_SHIFT+2 bits.
  - >>> is an arithmetic right shift (floor).
  - g is 0..2^FADE_SHIFT inclusive. The result is a convex combination, so no saturation is needed.
  - The result is registered; the slot output valid asserts 1 cycle after ret_vld.
- Per-slot latency = 1 (send register) + effect latency + 1 (mix register).
- Fade FSM per slot. It updates after each mix event, so the new g applies from the next sample.
  - OFF (g=0): tgt=1 -> FADE_IN.
  - FADE_IN: g += 1. At g=2^FADE_SHIFT -> ON. tgt=0 -> FADE_OUT from the current g, with no jump.
  - ON (g=max): tgt=0 -> FADE_OUT.
  - FADE_OUT: g -= 1. At g=0 -> OFF. tgt=1 -> FADE_IN from the current g.
- g=0 gives an output bit-exact to dry; g=max gives an output bit-exact to wet.
- FIFO boundary cases:
  - Push and pop in the same cycle: both take effect; the count is unchanged, and this holds even when the FIFO is full.
  - Push when full without a pop: the sample is still sent; no dry entry is stored; err[k] is set.
  - ret_vld when empty: the return is dropped; no output is produced; err[k] is set.
- Wrap-around: FIFO pointers are log2(DRY_DEPTH)+1 bits with natural wrap. Full and empty are distinguished by the MSB.
- err clears only on reset.
- Reset mid-operation clears all in-flight state. External effects share rst_n. Stale returns after release follow the underflow rule.

Optional Feature:
- EFF_CHAIN_FADE_EN defined:
  - Crossfade FSM and multipliers are present, as described above.
- EFF_CHAIN_FADE_EN undefined:
  - The FSM reduces to OFF/ON. g toggles directly between 0 and max at the next mix event after tgt changes.
  - The mixer becomes a wet/dry mux with no multipliers. Latency is identical.

Decomposition:
- eff_chain_pkg:
  - fade_state_t enum {OFF, FADE_IN, ON, FADE_OUT}.
  - Helper function for the slot slice offset.
  - Default widths.
- Sub-module eff_chain_stage: one slot, containing the dry FIFO, fade FSM and per-channel mixer.
- eff_chain instantiates NUM_STAGES eff_chain_stage instances in a generate loop, plus the tgt register.

Test Plan (loopback effects with 3-cycle latency unless noted; FADE_SHIFT=2, NUM_STAGES=2, NUM_CH=2):
- All sel=0; feed 10 samples with ch0=1000, ch1=-1000 -> data_o equals data_i bit-exact, latency 2*(1+3+1)=10 cycles, err=0.
- Slot0 effect returns the sample negated; en=1, sel=01, constant input 400 -> ch0 outputs over successive samples: 400, 200, 0, -200, -400, then -400 held (g=0,1,2,3,4 then max).
- Ramp reversal: sel goes 1 then 0 after 2 samples -> g sequence 0,1,2,1,0; outputs 400, 200, 0, 200, 400.
- Effect latency 20 cycles, vld_i every cycle, DRY_DEPTH=16 -> err[0]=1 at the 17th outstanding send; no error with DRY_DEPTH=32.
- Spurious ret_vld[1] with nothing sent -> no vld_o and err[1]=1; assert rst_n=0 -> err=0 and vld_o=0 immediately, asynchronously.
- With EFF_CHAIN_FADE_EN undefined -> a toggle of sel[0] switches ch0 from 400 to -400 in one sample; no intermediate values.
